wb_pipe_reg: RTL and testbench

Parametrised, flushable pipeline register for the MEM→WB boundary (and any other inter-stage boundary) with a valid/ready handshake. It carries an arbitrary-width payload plus writeback destination and write-enable fields. It replaces fixed-field, always-advancing stage flops with back-pressure, flush and occupancy reporting. An optional skid entry allows full throughput with a registered `in_ready`.

---
 rtl/wb_pipe_reg.sv | 122 ++++++++++++
 tb/tb_wb_pipe_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg.sv
// Flushable inter-stage pipeline register (MEM->WB style) with valid/ready handshake
// and occupancy. Define WB_PIPE_REG_SKID_EN to add a skid entry and a registered in_ready.
module wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
  } entry_t;

  entry_t     in_entry;
  entry_t     main_q;
  entry_t     main_n;
  logic       main_v;
  logic       main_v_n;
  logic       accept;
  logic       pop;
  logic       advance;
  logic [1:0] occ_n;

`ifdef WB_PIPE_REG_SKID_EN
  entry_t skid_q;
  entry_t skid_n;
  logic   skid_v;
  logic   skid_v_n;

  // Only flops and rst feed in_ready here, so out_ready never reaches upstream.
  assign in_ready = rst && !skid_v;
`else
  assign in_ready = rst && (!main_v || out_ready);
`endif

  assign in_entry = '{data: in_data, rd: in_rd, reg_write: in_reg_write};
  assign accept   = in_valid && in_ready;
  assign pop      = main_v && out_ready;
  assign advance  = pop || !main_v;
  assign occ_n    = occupancy + {1'b0, accept} - {1'b0, pop};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    main_n   = main_q;
    main_v_n = main_v;
`ifdef WB_PIPE_REG_SKID_EN
    skid_n   = skid_q;
    skid_v_n = skid_v;
`endif
    if (advance) begin
      main_v_n = accept;
      if (accept) main_n = in_entry;
`ifdef WB_PIPE_REG_SKID_EN
      // A held skid entry is older than anything upstream (in_ready was low), so it wins.
      if (skid_v) begin
        main_v_n = 1'b1;
        main_n   = skid_q;
        skid_v_n = 1'b0;
      end
`endif
    end
`ifdef WB_PIPE_REG_SKID_EN
    if (!advance && accept) begin
      skid_n   = in_entry;
      skid_v_n = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v    <= 1'b0;
      main_q    <= '0;
      occupancy <= '0;
`ifdef WB_PIPE_REG_SKID_EN
      skid_v    <= 1'b0;
`endif
    end else if (flush) begin
      main_v    <= 1'b0;
      occupancy <= '0;
`ifdef WB_PIPE_REG_SKID_EN
      skid_v    <= 1'b0;
`endif
    end else begin
      main_v    <= main_v_n;
      main_q    <= main_n;
      occupancy <= occ_n;
`ifdef WB_PIPE_REG_SKID_EN
      skid_v    <= skid_v_n;
`endif
    end
  end

`ifdef WB_PIPE_REG_SKID_EN
  // NOTE: the skid payload is qualified by skid_v, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_n;
  end
`endif

  assign out_valid     = main_v;
  assign out_data      = main_q.data;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_v && main_q.reg_write && (main_q.rd != '0);

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: FIFO-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with flush/reset.
module tb_wb_pipe_reg;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
`ifdef WB_PIPE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_reg_write;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_reg_write;
  logic [1:0]        occupancy;

  wb_pipe_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              rw;
  } ent_t;

  ent_t q[$];
  bit   m_acc;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Upstream may hand over an entry when the stage has room under the build's ready rule.
  function automatic bit exp_in_ready();
    if (!rst) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // Reference model: an ordered queue of held entries.
  always @(posedge clk) begin
    m_acc = 1'b0;
    if (!rst || flush) begin
      q.delete();
    end else begin
      bit acc;
      bit pp;
      acc = in_valid && exp_in_ready();
      pp  = (q.size() != 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{data: in_data, rd: in_rd, rw: in_reg_write});
      m_acc = acc;
    end
  end

  // Compare every cycle, mid-low-phase, after the stimulus has settled.
  always @(negedge clk) begin
    #2;
    check("in_ready", in_ready, exp_in_ready());
    check("out_valid", out_valid, q.size() != 0);
    check("occupancy", occupancy, q.size());
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_rd", out_rd, q[0].rd);
      check("out_reg_write", out_reg_write, q[0].rw && (q[0].rd != 0));
    end else begin
      check("out_reg_write_idle", out_reg_write, 1'b0);
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r,
                       input logic w, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = v; in_data = d; in_rd = r; in_reg_write = w; out_ready = ordy; flush = fl;
    #3;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h5555_5555; in_rd = 5'd7;
    in_reg_write = 1'b1; out_ready = 1'b0;

    // Reset held three cycles with in_valid high.
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_out_reg_write", out_reg_write, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #3;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_occupancy", occupancy, 2'd0);

    // Streaming.
    drive(1, 32'h11, 5'd5, 1, 1, 0);
    drive(1, 32'h22, 5'd5, 1, 1, 0);
    check("str0_data", out_data, 32'h11);
    check("str0_rw", out_reg_write, 1'b1);
    drive(1, 32'h33, 5'd5, 1, 1, 0);
    check("str1_data", out_data, 32'h22);
    check("str1_rw", out_reg_write, 1'b1);
    drive(0, 32'h0, 5'd0, 0, 1, 0);
    check("str2_data", out_data, 32'h33);
    check("str2_rw", out_reg_write, 1'b1);
    drive(0, 32'h0, 5'd0, 0, 1, 0);
    check("str_drained", out_valid, 1'b0);

    // x0 suppression.
    drive(1, 32'hDEAD, 5'd0, 1, 1, 0);
    drive(0, 32'h0, 5'd0, 0, 1, 0);
    check("x0_valid", out_valid, 1'b1);
    check("x0_data", out_data, 32'hDEAD);
    check("x0_rw", out_reg_write, 1'b0);
    drive(0, 32'h0, 5'd0, 0, 1, 0);

    // Back-pressure.
    drive(1, 32'hA, 5'd3, 1, 0, 0);
    check("bp_first_ready", in_ready, 1'b1);
    if (SKID) begin
      drive(1, 32'hB, 5'd4, 1, 0, 0);
      check("bp_skid_ready_b", in_ready, 1'b1);
      check("bp_head_a", out_data, 32'hA);
      drive(0, 32'h0, 5'd0, 0, 0, 0);
      check("bp_occ2", occupancy, 2'd2);
      check("bp_full_ready", in_ready, 1'b0);
      check("bp_hold_a", out_data, 32'hA);
      drive(0, 32'h0, 5'd0, 0, 1, 0);
      check("bp_out_a", out_data, 32'hA);
      drive(0, 32'h0, 5'd0, 0, 1, 0);
      check("bp_out_b", out_data, 32'hB);
      check("bp_ready_back", in_ready, 1'b1);
    end else begin
      drive(1, 32'hB, 5'd4, 1, 0, 0);
      check("bp_ns_blocked", in_ready, 1'b0);
      check("bp_ns_head_a", out_data, 32'hA);
      drive(1, 32'hB, 5'd4, 1, 0, 0);
      check("bp_ns_still_blocked", in_ready, 1'b0);
      drive(1, 32'hB, 5'd4, 1, 1, 0);
      check("bp_ns_ready_rise", in_ready, 1'b1);
      drive(0, 32'h0, 5'd0, 0, 1, 0);
      check("bp_ns_out_b", out_data, 32'hB);
    end
    drive(0, 32'h0, 5'd0, 0, 1, 0);
    check("bp_drained", out_valid, 1'b0);

    // Flush with entries held and a same-cycle incoming entry.
    drive(1, 32'hD, 5'd6, 1, 0, 0);
    if (SKID) drive(1, 32'hE, 5'd6, 1, 0, 0);
    drive(1, 32'hC, 5'd6, 1, 0, 1);
    drive(0, 32'h0, 5'd0, 0, 0, 0);
    check("fl_valid", out_valid, 1'b0);
    check("fl_occ", occupancy, 2'd0);
    drive(0, 32'h0, 5'd0, 0, 1, 0);
    check("fl_no_c", out_valid, 1'b0);

    // Randomized traffic; upstream holds each entry until accepted.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_acc || flush || !rst || !in_valid) begin
        in_valid     = ($urandom_range(0, 3) != 0);
        in_data      = $urandom;
        in_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : RD_W'($urandom_range(1, 31));
        in_reg_write = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
